// File: rtl/simmem_linkedlist_bank_rr.sv
// Multi-ID response bank: per-ID linked lists in one shared RAM, round-robin drain.
// Define SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN for fixed lowest-ID-first arbitration.
module simmem_linkedlist_bank_rr #(
    parameter int unsigned StructWidth   = 32,
    parameter int unsigned TotalCapacity = 16,
    parameter int unsigned IDWidth       = 2,
    localparam int unsigned NumIds       = 1 << IDWidth,
    localparam int unsigned CntW         = $clog2(TotalCapacity + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumIds-1:0]        release_en_i,
    input  logic [StructWidth-1:0]   data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [StructWidth-1:0]   data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [CntW-1:0]          free_cnt_o,
    output logic [NumIds*CntW-1:0]   id_cnt_o
);

    localparam int unsigned IdxW = $clog2(TotalCapacity);

    logic [StructWidth-1:0] payload_q [TotalCapacity];
    logic [IdxW-1:0]        next_q    [TotalCapacity];
    logic [IdxW-1:0]        next_d    [TotalCapacity];
    logic [IdxW-1:0]        head_q    [NumIds];
    logic [IdxW-1:0]        head_d    [NumIds];
    logic [IdxW-1:0]        tail_q    [NumIds];
    logic [IdxW-1:0]        tail_d    [NumIds];
    logic [CntW-1:0]        cnt_q     [NumIds];
    logic [CntW-1:0]        cnt_d     [NumIds];

    logic [TotalCapacity-1:0] free_q, free_d;
    logic [CntW-1:0]          free_cnt_q, free_cnt_d;
    logic                     locked_q, locked_d;
    logic [IDWidth-1:0]       lsel_q, lsel_d;

    logic [NumIds-1:0]  elig;
    logic [IDWidth-1:0] arb_sel, sel, push_id;
    logic [IdxW-1:0]    alloc_idx;
    logic [CntW-1:0]    push_cnt;
    logic               push, pop;

`ifndef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
    logic [IDWidth-1:0] rr_q, rr_d, cand;
`endif

    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            elig[i] = (cnt_q[i] != '0) && release_en_i[i];
            id_cnt_o[i*CntW +: CntW] = cnt_q[i];
        end
    end

    always_comb begin
        arb_sel = '0;
`ifdef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
        for (int i = NumIds - 1; i >= 0; i--) begin
            if (elig[i]) arb_sel = IDWidth'(i);
        end
`else
        cand = '0;
        // Scan farthest-first so the nearest eligible ID after rr_q wins.
        for (int k = NumIds; k >= 1; k--) begin
            cand = rr_q + IDWidth'(k);
            if (elig[cand]) arb_sel = cand;
        end
`endif
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = TotalCapacity - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = IdxW'(i);
        end
    end

    assign sel         = locked_q ? lsel_q : arb_sel;
    assign out_valid_o = locked_q || (|elig);
    assign data_o      = out_valid_o ? payload_q[head_q[sel]] : '0;
    assign in_ready_o  = rst_ni && (free_cnt_q != '0);
    assign free_cnt_o  = free_cnt_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign push_id     = data_i[IDWidth-1:0];

    always_comb begin
        next_d     = next_q;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;
        free_d     = free_q;
        locked_d   = locked_q;
        lsel_d     = lsel_q;
        push_cnt   = cnt_q[push_id];
`ifndef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
        rr_d       = rr_q;
`endif
        if (pop) begin
            free_d[head_q[sel]] = 1'b1;
            head_d[sel]         = next_q[head_q[sel]];
            cnt_d[sel]          = cnt_q[sel] - CntW'(1);
            locked_d            = 1'b0;
`ifndef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
            rr_d                = sel;
`endif
            if (sel == push_id) push_cnt = push_cnt - CntW'(1);
        end else if (out_valid_o) begin
            locked_d = 1'b1;
            lsel_d   = sel;
        end
        if (push) begin
            // A list drained by this cycle's pop restarts at the new entry.
            free_d[alloc_idx] = 1'b0;
            if (push_cnt == '0) head_d[push_id] = alloc_idx;
            else next_d[tail_q[push_id]] = alloc_idx;
            tail_d[push_id] = alloc_idx;
            cnt_d[push_id]  = cnt_d[push_id] + CntW'(1);
        end
        free_cnt_d = free_cnt_q - CntW'(push) + CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TotalCapacity; i++) next_q[i] <= '0;
            for (int i = 0; i < NumIds; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            free_q     <= '1;
            free_cnt_q <= CntW'(TotalCapacity);
            locked_q   <= 1'b0;
            lsel_q     <= '0;
`ifndef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
            rr_q       <= IDWidth'(NumIds - 1);
`endif
        end else begin
            next_q     <= next_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            free_q     <= free_d;
            free_cnt_q <= free_cnt_d;
            locked_q   <= locked_d;
            lsel_q     <= lsel_d;
`ifndef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
            rr_q       <= rr_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) payload_q[alloc_idx] <= data_i;
    end

    a_pop_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> cnt_q[sel] != '0);
    a_id_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> cnt_q[push_id] != CntW'(TotalCapacity));
    a_free_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push && !pop) |-> free_cnt_q != '0);
    a_free_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pop && !push) |-> free_cnt_q != CntW'(TotalCapacity));

endmodule

// File: tb/tb_simmem_linkedlist_bank_rr.sv
// Randomized bench for simmem_linkedlist_bank_rr against a per-ID queue model.
module tb_simmem_linkedlist_bank_rr;
    localparam int SW = 32;
    localparam int TC = 16;
    localparam int NI = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] rel = '0;
    logic [SW-1:0] din = '0;
    logic          iv = 1'b0;
    logic          ordy = 1'b0;
    logic          in_ready, out_valid;
    logic [SW-1:0] dout;
    logic [CW-1:0] free_cnt;
    logic [NI*CW-1:0] id_cnt;

    always #5 clk = ~clk;

    simmem_linkedlist_bank_rr dut (
        .clk_i(clk), .rst_ni(rst_n), .release_en_i(rel),
        .data_i(din), .in_valid_i(iv), .in_ready_o(in_ready),
        .data_o(dout), .out_valid_o(out_valid), .out_ready_i(ordy),
        .free_cnt_o(free_cnt), .id_cnt_o(id_cnt)
    );

    int vectors = 0;
    int errors = 0;

    logic [SW-1:0] mq [NI][$];
    int m_rr;
    bit m_lock;
    int m_lsel;
    int pops[$];

    bit p_ready, p_valid;
    int p_sel;
    logic [SW-1:0] p_data;
    logic [NI*CW-1:0] p_idcnt;
    int p_free;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] mkd(int id);
        logic [SW-1:0] x;
        x = $urandom();
        x[1:0] = id[1:0];
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) mq[i].delete();
        m_rr = NI - 1;
        m_lock = 0;
        m_lsel = 0;
    endtask

    task automatic predict();
        int tot;
        bit found;
        tot = 0;
        p_idcnt = '0;
        for (int i = 0; i < NI; i++) begin
            tot += mq[i].size();
            p_idcnt[i*CW +: CW] = CW'(mq[i].size());
        end
        p_free = TC - tot;
        p_ready = rst_n && (tot < TC);
        p_valid = 0;
        p_sel = 0;
        found = 0;
        if (m_lock) begin
            p_valid = 1;
            p_sel = m_lsel;
        end else begin
`ifdef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
            for (int i = 0; i < NI; i++)
                if (!found && mq[i].size() > 0 && rel[i]) begin
                    found = 1;
                    p_sel = i;
                end
`else
            for (int k = 1; k <= NI; k++)
                if (!found && mq[(m_rr + k) % NI].size() > 0 && rel[(m_rr + k) % NI]) begin
                    found = 1;
                    p_sel = (m_rr + k) % NI;
                end
`endif
            p_valid = found;
        end
        p_data = p_valid ? mq[p_sel][0] : '0;
    endtask

    task automatic step(bit v, logic [SW-1:0] d, logic [NI-1:0] r, bit o);
        bit pu, po;
        iv = v; din = d; rel = r; ordy = o;
        #1;
        predict();
        chk("in_ready", 64'(in_ready), 64'(p_ready));
        chk("out_valid", 64'(out_valid), 64'(p_valid));
        chk("data_o", 64'(dout), 64'(p_data));
        chk("free_cnt", 64'(free_cnt), 64'(p_free));
        chk("id_cnt", 64'(id_cnt), 64'(p_idcnt));
        pu = v && p_ready;
        po = p_valid && o;
        @(posedge clk);
        if (po) begin
            void'(mq[p_sel].pop_front());
            pops.push_back(p_sel);
            m_rr = p_sel;
            m_lock = 0;
        end else if (p_valid) begin
            m_lock = 1;
            m_lsel = p_sel;
        end
        if (pu) mq[d[1:0]].push_back(d);
        @(negedge clk);
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(dout), 64'd0);
        chk({tag, "_free"}, 64'(free_cnt), 64'd16);
        chk({tag, "_idcnt"}, 64'(id_cnt), 64'd0);
    endtask

    initial begin
        logic [SW-1:0] nd, d3;
        int exp_pops [10];
        int exp_fp [6];
        bit burst;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) step(1, mkd(i % 4), 4'b0000, 0);
        chk("fill_free", 64'(free_cnt), 64'd6);
        chk("fill_idcnt", 64'(id_cnt), 64'({5'd2, 5'd2, 5'd3, 5'd3}));
        chk("fill_valid", 64'(out_valid), 64'd0);

        pops.delete();
`ifdef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
        exp_pops = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3};
`else
        exp_pops = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
`endif
        for (int i = 0; i < 10; i++) step(0, '0, 4'b1111, 1);
        for (int i = 0; i < 10; i++) chk("pop_order", 64'(pops[i]), 64'(exp_pops[i]));
        chk("drain_free", 64'(free_cnt), 64'd16);

        for (int i = 0; i < 16; i++) step(1, mkd(2), 4'b0000, 0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_free", 64'(free_cnt), 64'd0);
        step(1, mkd(2), 4'b0100, 1);
        chk("full_pop_free", 64'(free_cnt), 64'd1);
        chk("full_pop_ready", 64'(in_ready), 64'd1);
        step(1, mkd(2), 4'b0100, 0);
        chk("full_refill_free", 64'(free_cnt), 64'd0);
        for (int i = 0; i < 17; i++) step(0, '0, 4'b1111, 1);
        chk("empty_free", 64'(free_cnt), 64'd16);

        step(1, mkd(1), 4'b0000, 0);
        nd = mkd(1);
        step(1, nd, 4'b0010, 1);
        iv = 0; ordy = 0; #1;
        chk("same_id_valid", 64'(out_valid), 64'd1);
        chk("same_id_data", 64'(dout), 64'(nd));
        chk("same_id_cnt", 64'(id_cnt[9:5]), 64'd1);
        step(0, '0, 4'b0010, 1);

        d3 = mkd(3);
        step(1, d3, 4'b0000, 0);
        step(0, '0, 4'b1000, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 4'b0000, 0);
        rel = 4'b0000; #1;
        chk("lock_valid", 64'(out_valid), 64'd1);
        chk("lock_data", 64'(dout), 64'(d3));
        step(0, '0, 4'b0000, 1);
        chk("lock_released", 64'(out_valid), 64'd0);

        for (int i = 0; i < 3; i++) step(1, mkd(0), 4'b0000, 0);
        for (int i = 0; i < 3; i++) step(1, mkd(2), 4'b0000, 0);
        pops.delete();
`ifdef SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
        exp_fp = '{0, 0, 0, 2, 2, 2};
`else
        exp_fp = '{0, 2, 0, 2, 0, 2};
`endif
        for (int i = 0; i < 6; i++) step(0, '0, 4'b0101, 1);
        for (int i = 0; i < 6; i++) chk("prio_order", 64'(pops[i]), 64'(exp_fp[i]));

        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) burst = ~burst;
            step(($urandom % 4) != 0, mkd($urandom % 4), 4'($urandom),
                 burst ? (($urandom % 5) == 0) : (($urandom % 3) != 0));
        end

        iv = 0; ordy = 0;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++)
            step(($urandom % 3) != 0, mkd($urandom % 4), 4'($urandom), ($urandom % 2) != 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/simmem_linkedlist_bank_rr.md
Name: simmem_linkedlist_bank_rr

Overview:
- Shared-storage, multi-ID response bank for the simulated memory controller.
- Messages carry an ID in their low IDWidth bits. Each ID has its own linked list inside one common RAM of TotalCapacity entries; order is FIFO within an ID.
- Per-ID release enables gate which lists may drain. A round-robin arbiter picks among the released, non-empty IDs.
- Successor to the single-arbitration linked-list bank: adds fairness, occupancy outputs and defined simultaneous push/pop behaviour.

Parameters:
- StructWidth, 32, message width including ID field (bits [IDWidth-1:0]).
- TotalCapacity, 16, shared entries across all IDs (>=2).
- IDWidth, 2, ID field width; NumIds = 2**IDWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- release_en_i  in  NumIds  per-ID drain enable
- data_i  in  StructWidth  input message
- in_valid_i  in  1  input valid
- in_ready_o  out  1  input ready
- data_o  out  StructWidth  output message
- out_valid_o  out  1  output valid
- out_ready_i  in  1  output ready
- free_cnt_o  out  $clog2(TotalCapacity+1)  free entries
- id_cnt_o  out  NumIds*$clog2(TotalCapacity+1)  per-ID occupancy, ID0 in LSBs

Behaviour:
- Reset values:
  - in_ready_o=0 while rst_ni low, then 1.
  - out_valid_o=0, data_o='0, free_cnt_o=TotalCapacity, id_cnt_o='0.
  - All heads, tails and next pointers = 0; free mask all ones.
  - RR pointer = NumIds-1, so ID0 has first priority.
- Storage:
  - Each RAM entry holds a payload and a next pointer.
  - The free list is a bitmask. Allocation takes the lowest-index free entry.
  - Per ID: head, tail and count registers.
- Push:
  - in_ready_o = (free_cnt != 0), computed from registered state only.
  - On in_valid_i && in_ready_o: write data_i to the allocated entry idx.
  - If count[id]==0 after this cycle's pop is accounted: head=tail=idx. Otherwise next[tail]=idx and tail=idx.
  - count[id]++ and free_cnt-- take effect the next cycle.
- Eligibility and selection:
  - eligible[i] = count[i]!=0 && release_en_i[i], on registered count.
  - An entry pushed in cycle N is eligible no earlier than cycle N+1 (min accept-to-out_valid latency 1).
  - Unlocked: sel = first eligible ID strictly after the RR pointer, wrapping.
  - out_valid_o = locked || |eligible.
  - data_o = payload at head[sel], combinational from RAM; '0 when out_valid_o=0.
- Lock (handshake stability):
  - When out_valid_o=1 and out_ready_i=0, sel and data_o are frozen until the handshake.
  - Deasserting release_en_i[sel] while locked does not drop out_valid_o.
- Pop:
  - On out_valid_o && out_ready_i: free head[sel], head[sel]=next[head[sel]], count[sel]--, free_cnt++, RR pointer=sel, unlock.
- Simultaneous push and pop:
  - Both are allowed in the same cycle; free_cnt ends unchanged.
  - The entry freed this cycle is not allocatable in the same cycle.
  - Same ID with count==1: new head=tail=new idx.
  - Same ID with count>1: link to the old tail; a new head comes from the pop.
- Full: with free_cnt==0, in_ready_o=0 even if a pop occurs that cycle; ready rises the following cycle.
- Empty: all counts 0, or no released ID, with no lock → out_valid_o=0.
- Reset mid-operation: all state returns to reset values immediately; queued messages are discarded.
- Widths: counters saturate-free by construction. An overflow or underflow is a design error; flag it with a simulation assertion.

Optional Feature:
- SIMMEM_LINKEDLIST_BANK_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, lowest eligible ID wins, and the RR pointer is removed. Lock rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then 10 pushes of IDs 0,1,2,3,0,1,... with release_en_i=0 → free_cnt_o=6, id_cnt_o={2,2,3,3} for ID3..ID0, out_valid_o=0.
- Set release_en_i=4'b1111 with out_ready_i=1 → pops in ID order 0,1,2,3,0,1,2,3,0,1; per-ID payload order preserved; free_cnt_o returns to 16.
- Fill all 16 entries with ID2 → in_ready_o=0. Pop once with a push offered the same cycle → push rejected that cycle, accepted the next; free_cnt_o goes 0→1→0.
- ID1 has 1 entry; push an ID1 message during the pop of that entry → out_valid_o=1 next cycle with the new message; id_cnt_o[ID1]=1.
- Hold out_ready_i=0 with ID3 presented, then drop release_en_i[3] → out_valid_o stays 1 and data_o stays stable until out_ready_i=1.
- With FIXED_PRIO_EN defined, keep IDs 0 and 2 non-empty and both released → ID0 always wins until empty.
